// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding select encodings, controller states and the hard-wired zero register.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding select for one EX-stage source operand.
// A pending write in MEM is newer than one in WB, so it wins.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       exmem_reg_write_i,
    input  logic [4:0] memwb_rd_i,
    input  logic       memwb_reg_write_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (exmem_reg_write_i && (exmem_rd_i != REG_ZERO) && (exmem_rd_i == src_i)) begin
            fwd_o = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_i != REG_ZERO) && (memwb_rd_i == src_i)) begin
            fwd_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: memory-latency freeze, taken-branch
// flush, load-use bubble, EX forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DM_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic             idex_mem_read,
    input  logic             branch_taken,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_reg_write,
    input  logic             exmem_mem_access,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_reg_write,
    output logic             pc_write,
    output logic             pc_src_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam bit              MULTI_CYCLE = (DM_LATENCY > 1);
    localparam int              WAIT_W      = (DM_LATENCY > 2) ? $clog2(DM_LATENCY - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((DM_LATENCY > 2) ? DM_LATENCY - 2 : 0);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               freeze;
    logic               loadUseHit;
    logic               branchAct;
    logic               loadUseAct;
    logic [1:0]         fwdA, fwdB;

    pipe_hazard_ctrl_fwd_unit u_fwd_a (
        .src_i             (idex_rs),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .fwd_o             (fwdA)
    );

    pipe_hazard_ctrl_fwd_unit u_fwd_b (
        .src_i             (idex_rt),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .fwd_o             (fwdB)
    );

    // The triggering cycle freezes too, so the wait only needs DM_LATENCY-2 more;
    // the cnt==0 cycle in MEM_WAIT releases and ignores the still-visible access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        case (state_q)
            RUN: begin
                if (MULTI_CYCLE && exmem_mem_access) begin
                    freeze  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (cnt_q != '0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign loadUseHit = idex_mem_read && (idex_rt != REG_ZERO) &&
                        ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign branchAct  = !freeze && branch_taken;
    assign loadUseAct = !freeze && !branch_taken && loadUseHit;

    always_comb begin
        pc_write      = 1'b1;
        pc_src_branch = 1'b0;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_flush    = 1'b0;
        exmem_write   = 1'b1;
        memwb_flush   = 1'b0;
        fwd_a         = fwdA;
        fwd_b         = fwdB;
        busy          = (state_q == MEM_WAIT);
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
            busy        = 1'b0;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
        end else if (branchAct) begin
            pc_src_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end else if (loadUseAct) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((freeze || loadUseAct) && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench: three controllers (DM_LATENCY 1, 3, 4) share one stimulus
// stream and are compared every cycle against a cycle-position reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic       ifid_uses_rt, idex_mem_read, branch_taken;
    logic       exmem_reg_write, exmem_mem_access, memwb_reg_write;

    logic       pcWrite[3], pcSrc[3], ifidWrite[3], ifidFlush[3];
    logic       idexWrite[3], idexFlush[3], exmemWrite[3], memwbFlush[3], busyO[3];
    logic [1:0] fwdA[3], fwdB[3];
    logic [3:0]  stall0;
    logic [15:0] stall1, stall2;

    int latency[3] = '{1, 3, 4};
    int cntMax[3]  = '{15, 65535, 65535};
    int pos[3];
    int stallCnt[3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DM_LATENCY(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read), .branch_taken(branch_taken),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_access(exmem_mem_access),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .pc_write(pcWrite[0]), .pc_src_branch(pcSrc[0]), .ifid_write(ifidWrite[0]), .ifid_flush(ifidFlush[0]),
        .idex_write(idexWrite[0]), .idex_flush(idexFlush[0]), .exmem_write(exmemWrite[0]),
        .memwb_flush(memwbFlush[0]), .fwd_a(fwdA[0]), .fwd_b(fwdB[0]), .busy(busyO[0]), .stall_cycles(stall0)
    );

    pipe_hazard_ctrl #(.DM_LATENCY(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read), .branch_taken(branch_taken),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_access(exmem_mem_access),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .pc_write(pcWrite[1]), .pc_src_branch(pcSrc[1]), .ifid_write(ifidWrite[1]), .ifid_flush(ifidFlush[1]),
        .idex_write(idexWrite[1]), .idex_flush(idexFlush[1]), .exmem_write(exmemWrite[1]),
        .memwb_flush(memwbFlush[1]), .fwd_a(fwdA[1]), .fwd_b(fwdB[1]), .busy(busyO[1]), .stall_cycles(stall1)
    );

    pipe_hazard_ctrl #(.DM_LATENCY(4), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read), .branch_taken(branch_taken),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_access(exmem_mem_access),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .pc_write(pcWrite[2]), .pc_src_branch(pcSrc[2]), .ifid_write(ifidWrite[2]), .ifid_flush(ifidFlush[2]),
        .idex_write(idexWrite[2]), .idex_flush(idexFlush[2]), .exmem_write(exmemWrite[2]),
        .memwb_flush(memwbFlush[2]), .fwd_a(fwdA[2]), .fwd_b(fwdB[2]), .busy(busyO[2]), .stall_cycles(stall2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [4:0] src, input logic [4:0] exRd, input logic exWr,
                                          input logic [4:0] wbRd, input logic wbWr);
        if (exWr && exRd != 5'd0 && exRd == src) return 2'b10;
        if (wbWr && wbRd != 5'd0 && wbRd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Small register range so that address collisions (and $0) are frequent.
    task automatic applyStimulus(input bit forceReset);
        rst              = forceReset || ($urandom_range(0, 199) == 0);
        ifid_rs          = 5'($urandom_range(0, 3));
        ifid_rt          = 5'($urandom_range(0, 3));
        ifid_uses_rt     = 1'($urandom_range(0, 1));
        idex_rs          = 5'($urandom_range(0, 3));
        idex_rt          = 5'($urandom_range(0, 3));
        idex_mem_read    = ($urandom_range(0, 2) == 0);
        branch_taken     = ($urandom_range(0, 7) == 0);
        exmem_rd         = 5'($urandom_range(0, 3));
        exmem_reg_write  = 1'($urandom_range(0, 1));
        exmem_mem_access = ($urandom_range(0, 2) == 0);
        memwb_rd         = 5'($urandom_range(0, 3));
        memwb_reg_write  = 1'($urandom_range(0, 1));
    endtask

    task automatic checkCycle();
        bit freeze, isBusy, br, lu, luHit;
        logic [1:0] expA, expB;
        logic [31:0] stallObs;
        string sfx;
        luHit = idex_mem_read && idex_rt != 5'd0 &&
                (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
        expA = refFwd(idex_rs, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        expB = refFwd(idex_rt, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        for (int i = 0; i < 3; i++) begin
            sfx = $sformatf("[L%0d]", latency[i]);
            if (pos[i] < 0) begin
                isBusy = 1'b0;
                freeze = exmem_mem_access && latency[i] > 1;
            end else begin
                isBusy = 1'b1;
                freeze = pos[i] < latency[i] - 1;
            end
            br = !freeze && branch_taken;
            lu = !freeze && !branch_taken && luHit;
            case (i)
                0:       stallObs = 32'(stall0);
                1:       stallObs = 32'(stall1);
                default: stallObs = 32'(stall2);
            endcase
            checkOutput({"stall_cycles", sfx}, stallObs, 32'(stallCnt[i]));
            if (rst) begin
                checkOutput({"pc_write", sfx},      32'(pcWrite[i]),    32'd0);
                checkOutput({"pc_src_branch", sfx}, 32'(pcSrc[i]),      32'd0);
                checkOutput({"ifid_write", sfx},    32'(ifidWrite[i]),  32'd0);
                checkOutput({"ifid_flush", sfx},    32'(ifidFlush[i]),  32'd1);
                checkOutput({"idex_write", sfx},    32'(idexWrite[i]),  32'd0);
                checkOutput({"idex_flush", sfx},    32'(idexFlush[i]),  32'd1);
                checkOutput({"exmem_write", sfx},   32'(exmemWrite[i]), 32'd0);
                checkOutput({"memwb_flush", sfx},   32'(memwbFlush[i]), 32'd1);
                checkOutput({"fwd_a", sfx},         32'(fwdA[i]),       32'd0);
                checkOutput({"fwd_b", sfx},         32'(fwdB[i]),       32'd0);
                checkOutput({"busy", sfx},          32'(busyO[i]),      32'd0);
                pos[i]      = -1;
                stallCnt[i] = 0;
            end else begin
                checkOutput({"pc_write", sfx},      32'(pcWrite[i]),    32'(!(freeze || lu)));
                checkOutput({"pc_src_branch", sfx}, 32'(pcSrc[i]),      32'(br));
                checkOutput({"ifid_write", sfx},    32'(ifidWrite[i]),  32'(!(freeze || lu)));
                checkOutput({"ifid_flush", sfx},    32'(ifidFlush[i]),  32'(br));
                checkOutput({"idex_write", sfx},    32'(idexWrite[i]),  32'(!freeze));
                checkOutput({"idex_flush", sfx},    32'(idexFlush[i]),  32'(br || lu));
                checkOutput({"exmem_write", sfx},   32'(exmemWrite[i]), 32'(!freeze));
                checkOutput({"memwb_flush", sfx},   32'(memwbFlush[i]), 32'(freeze));
                checkOutput({"fwd_a", sfx},         32'(fwdA[i]),       32'(expA));
                checkOutput({"fwd_b", sfx},         32'(fwdB[i]),       32'(expB));
                checkOutput({"busy", sfx},          32'(busyO[i]),      32'(isBusy));
                if (freeze) pos[i] = (pos[i] < 0) ? 1 : pos[i] + 1;
                else        pos[i] = -1;
                if ((freeze || lu) && stallCnt[i] < cntMax[i]) stallCnt[i]++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pos[i]      = -1;
            stallCnt[i] = 0;
        end
        applyStimulus(1'b1);
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            #1;
            applyStimulus(cyc == 0);
            #3;
            checkCycle();
            @(posedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
